// File: rtl/pipe_ctrl_pkg.sv
// Shared stage-condition encodings, FSM states and the per-stage condition bundle for pipeline_ctrl.
// Optional build macro elsewhere in this slice: PIPE_STALL_STATS_EN.
package pipe_ctrl_pkg;

    localparam logic [1:0] COND_FLUSH   = 2'd0;
    localparam logic [1:0] COND_ADVANCE = 2'd1;
    localparam logic [1:0] COND_HOLD    = 2'd2;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0] pc;
        logic [1:0] ifid;
        logic [1:0] idex;
        logic [1:0] exmem;
        logic [1:0] memwb;
    } pipe_cond_t;

    function automatic pipe_cond_t cond_all(input logic [1:0] c);
        return '{pc: c, ifid: c, idex: c, exmem: c, memwb: c};
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags when the load in EX writes a register the ID instruction reads.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_load_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    input  logic       rt_valid_i,
    output logic       load_use_o
);

    // r0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use_o = ex_load_i && (ex_rd_i != 5'd0) &&
                        ((ex_rd_i == rs_i) || (rt_valid_i && (ex_rd_i == rt_i)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: post-reset flush, load-use / branch / jump resolution and data-memory stalls.
// Define PIPE_STALL_STATS_EN to add the stall_cycles / flush_events statistics outputs.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned INIT_FLUSH  = 4,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] IFID_Rs,
    input  logic [4:0] IFID_Rt,
    input  logic       IFID_UsesRt,
    input  logic       IDEX_MemRead,
    input  logic [4:0] IDEX_RegWriteAddr,
    input  logic       EX_BranchTaken,
    input  logic       ID_Jump,
    input  logic       dmem_req,
    input  logic       dmem_ready,
`ifdef PIPE_STALL_STATS_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events,
`endif
    output logic [1:0] PC_condition,
    output logic [1:0] IFID_condition,
    output logic [1:0] IDEX_condition,
    output logic [1:0] EXMEM_condition,
    output logic [1:0] MEMWB_condition,
    output logic       mem_err
);

    localparam int unsigned INIT_W = 4;
    localparam int unsigned WAIT_W = 16;

    localparam pipe_cond_t COND_MEM_STALL =
        '{pc: COND_HOLD, ifid: COND_HOLD, idex: COND_HOLD, exmem: COND_HOLD, memwb: COND_FLUSH};
    localparam pipe_cond_t COND_LOAD_USE =
        '{pc: COND_HOLD, ifid: COND_HOLD, idex: COND_FLUSH, exmem: COND_ADVANCE, memwb: COND_ADVANCE};
    localparam pipe_cond_t COND_BRANCH =
        '{pc: COND_ADVANCE, ifid: COND_FLUSH, idex: COND_FLUSH, exmem: COND_ADVANCE, memwb: COND_ADVANCE};
    localparam pipe_cond_t COND_JUMP =
        '{pc: COND_ADVANCE, ifid: COND_FLUSH, idex: COND_ADVANCE, exmem: COND_ADVANCE, memwb: COND_ADVANCE};

    state_e              state_q, state_d;
    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_err_q, mem_err_d;
    logic                load_use;
    logic                mem_stall;
    logic                ctrl_flush;
    pipe_cond_t          cond_c;

    hazard_detect u_hazard_detect (
        .ex_load_i  (IDEX_MemRead),
        .ex_rd_i    (IDEX_RegWriteAddr),
        .rs_i       (IFID_Rs),
        .rt_i       (IFID_Rt),
        .rt_valid_i (IFID_UsesRt),
        .load_use_o (load_use)
    );

    assign mem_stall = dmem_req && !dmem_ready;

    // Next state and Mealy stage conditions.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        cond_c     = cond_all(COND_ADVANCE);
        ctrl_flush = 1'b0;
        case (state_q)
            ST_INIT: begin
                cond_c = cond_all(COND_FLUSH);
                if (init_cnt_q == INIT_W'(INIT_FLUSH - 1)) begin
                    state_d    = ST_RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + INIT_W'(1);
                end
            end
            ST_RUN: begin
                if (mem_stall) begin
                    cond_c     = COND_MEM_STALL;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end else if (load_use) begin
                    cond_c = COND_LOAD_USE;
                end else if (EX_BranchTaken) begin
                    cond_c     = COND_BRANCH;
                    ctrl_flush = 1'b1;
                end else if (ID_Jump) begin
                    cond_c     = COND_JUMP;
                    ctrl_flush = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
                    // Access is abandoned; the pipeline moves on and the error is latched.
                    mem_err_d = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    cond_c     = COND_MEM_STALL;
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                cond_c  = cond_all(COND_FLUSH);
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

`ifdef PIPE_STALL_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    // Saturating statistics counters.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if ((state_q != ST_INIT) && (cond_c.pc == COND_HOLD) && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (ctrl_flush && (flush_events_q != 32'hFFFF_FFFF)) begin
            flush_events_d = flush_events_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

    assign PC_condition    = cond_c.pc;
    assign IFID_condition  = cond_c.ifid;
    assign IDEX_condition  = cond_c.idex;
    assign EXMEM_condition = cond_c.exmem;
    assign MEMWB_condition = cond_c.memwb;
    assign mem_err         = mem_err_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (INIT_FLUSH=4, MEM_TIMEOUT=8).
// Connects the PIPE_STALL_STATS_EN ports when that macro is defined.
module tb_pipeline_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] IFID_Rs, IFID_Rt, IDEX_RegWriteAddr;
    logic       IFID_UsesRt, IDEX_MemRead, EX_BranchTaken, ID_Jump, dmem_req, dmem_ready;
    logic [1:0] PC_condition, IFID_condition, IDEX_condition, EXMEM_condition, MEMWB_condition;
    logic       mem_err;
`ifdef PIPE_STALL_STATS_EN
    logic [31:0] stall_cycles, flush_events;
`endif
    logic [9:0] conds;

    int n_checks = 0;
    int n_fail   = 0;

    // {PC, IFID, IDEX, EXMEM, MEMWB}, two bits each
    localparam logic [9:0] ALL_FLUSH = 10'h000;
    localparam logic [9:0] ALL_ADV   = 10'h155;
    localparam logic [9:0] LOAD_USE  = 10'h285;
    localparam logic [9:0] BRANCH    = 10'h105;
    localparam logic [9:0] JUMP      = 10'h115;
    localparam logic [9:0] MEM_STALL = 10'h2A8;

    pipeline_ctrl #(.INIT_FLUSH(4), .MEM_TIMEOUT(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .IFID_Rs           (IFID_Rs),
        .IFID_Rt           (IFID_Rt),
        .IFID_UsesRt       (IFID_UsesRt),
        .IDEX_MemRead      (IDEX_MemRead),
        .IDEX_RegWriteAddr (IDEX_RegWriteAddr),
        .EX_BranchTaken    (EX_BranchTaken),
        .ID_Jump           (ID_Jump),
        .dmem_req          (dmem_req),
        .dmem_ready        (dmem_ready),
`ifdef PIPE_STALL_STATS_EN
        .stall_cycles      (stall_cycles),
        .flush_events      (flush_events),
`endif
        .PC_condition      (PC_condition),
        .IFID_condition    (IFID_condition),
        .IDEX_condition    (IDEX_condition),
        .EXMEM_condition   (EXMEM_condition),
        .MEMWB_condition   (MEMWB_condition),
        .mem_err           (mem_err)
    );

    assign conds = {PC_condition, IFID_condition, IDEX_condition, EXMEM_condition, MEMWB_condition};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are set just after posedge; outputs are checked on the following negedge.
    task automatic expect_cond(input string tag, input logic [9:0] exp);
        @(negedge clk);
        check(tag, 32'(conds), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        IFID_Rs = 5'd0; IFID_Rt = 5'd0; IFID_UsesRt = 1'b0;
        IDEX_MemRead = 1'b0; IDEX_RegWriteAddr = 5'd0;
        EX_BranchTaken = 1'b0; ID_Jump = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();

        @(negedge clk);
        check("reset_conds", 32'(conds), 32'(ALL_FLUSH));
        check("reset_mem_err", 32'(mem_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) expect_cond("init_flush", ALL_FLUSH);
        expect_cond("first_run", ALL_ADV);

        // Load-use via Rs, then the bubble has removed the load
        IDEX_MemRead = 1'b1; IDEX_RegWriteAddr = 5'd5; IFID_Rs = 5'd5;
        expect_cond("load_use_rs", LOAD_USE);
        IDEX_MemRead = 1'b0;
        expect_cond("load_use_after", ALL_ADV);
        // Load-use via Rt, only when Rt is read
        IDEX_MemRead = 1'b1; IDEX_RegWriteAddr = 5'd7; IFID_Rs = 5'd1; IFID_Rt = 5'd7; IFID_UsesRt = 1'b1;
        expect_cond("load_use_rt", LOAD_USE);
        IFID_UsesRt = 1'b0;
        expect_cond("load_use_rt_unused", ALL_ADV);
        // r0 destination never stalls
        IDEX_RegWriteAddr = 5'd0; IFID_Rs = 5'd0;
        expect_cond("load_use_r0", ALL_ADV);
        clear_inputs();

        EX_BranchTaken = 1'b1; ID_Jump = 1'b1;
        expect_cond("branch_and_jump", BRANCH);
        EX_BranchTaken = 1'b0;
        expect_cond("jump_only", JUMP);
        ID_Jump = 1'b0;
        expect_cond("idle", ALL_ADV);

        // Memory stall beats a taken branch; branch resolves after release
        dmem_req = 1'b1; dmem_ready = 1'b0; EX_BranchTaken = 1'b1;
        expect_cond("mem_stall_first", MEM_STALL);
        for (int i = 0; i < 3; i++) expect_cond("mem_wait_hold", MEM_STALL);
        dmem_ready = 1'b1;
        expect_cond("mem_wait_release", ALL_ADV);
        dmem_req = 1'b0; dmem_ready = 1'b0;
        expect_cond("branch_after_release", BRANCH);
        clear_inputs();

        dmem_req = 1'b1; dmem_ready = 1'b1;
        expect_cond("mem_ready_same_cycle", ALL_ADV);
        dmem_req = 1'b0; dmem_ready = 1'b0;
        expect_cond("mem_no_wait_state", ALL_ADV);

        // Timeout: one RUN stall cycle, 8 wait cycles, then forced release
        dmem_req = 1'b1;
        expect_cond("timeout_first", MEM_STALL);
        for (int i = 0; i < 8; i++) expect_cond("timeout_hold", MEM_STALL);
        check("mem_err_before_timeout", 32'(mem_err), 32'd0);
        expect_cond("timeout_release", ALL_ADV);
        dmem_req = 1'b0;
        check("mem_err_set", 32'(mem_err), 32'd1);
        expect_cond("after_timeout", ALL_ADV);
        check("mem_err_sticky", 32'(mem_err), 32'd1);

        // Reset asserted in the middle of MEM_WAIT
        dmem_req = 1'b1;
        expect_cond("stall_before_reset", MEM_STALL);
        expect_cond("wait_before_reset", MEM_STALL);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_conds", 32'(conds), 32'(ALL_FLUSH));
        check("async_reset_mem_err", 32'(mem_err), 32'd0);
        clear_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) expect_cond("init_replay", ALL_FLUSH);
        expect_cond("run_after_replay", ALL_ADV);
        check("mem_err_after_replay", 32'(mem_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
